// File: rtl/p2s_pkg.sv
// Shared types and elaboration helpers for the parallel-to-serial stream block.
// Latency: n/a (types, constants and constant functions only).
// Backpressure: n/a.
package p2s_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } p2s_state_t;

  localparam int P2S_MIN_W = 2;
  localparam int P2S_MAX_W = 64;

  // Bit counter width; indexes 0..data_w-1.
  function automatic int p2s_cnt_w(input int data_w);
    return (data_w < 2) ? 1 : $clog2(data_w);
  endfunction

  function automatic bit p2s_width_ok(input int data_w);
    return (data_w >= P2S_MIN_W) && (data_w <= P2S_MAX_W);
  endfunction

endpackage

// File: rtl/p2s_hold_buf.sv
// Single-entry holding buffer for the word that arrives while a frame is shifting.
// Latency: word visible on hold_data the cycle after capture; pop clears full next cycle.
// Backpressure: in_ready = !hold_full, driven straight from the flag register.
// Ports: clk, rst (async, active-high); in_valid/in_data/in_ready producer side;
//        capture = shifter is busy, so a handshake lands here; pop = shifter takes the word;
//        hold_data/hold_full = stored word and occupancy.
module p2s_hold_buf
  import p2s_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              capture,
  input  logic              pop,
  output logic              in_ready,
  output logic [DATA_W-1:0] hold_data,
  output logic              hold_full
);

  assign in_ready = !hold_full;

  // Capture needs an empty buffer and pop needs a full one, so they never coincide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_full <= 1'b0;
      hold_data <= '0;
    end else if (in_valid && in_ready && capture) begin
      hold_full <= 1'b1;
      hold_data <= in_data;
    end else if (pop) begin
      hold_full <= 1'b0;
    end
  end

endmodule

// File: rtl/parallel2serial_stream.sv
// Parallel-to-serial converter: DATA_W-bit words in over valid/ready, one bit per clock out.
// Latency: first bit registered the cycle after the handshake; back-to-back frames have no gap.
// Backpressure: in_ready drops only while a second word sits in the holding buffer.
// Ports: clk, rst (async, active-high); in_valid/in_data/in_ready word input;
//        serial_valid/serial_out/serial_start/serial_end registered bit stream; busy status.
module parallel2serial_stream
  import p2s_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter bit LSB_FIRST  = 1'b0,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              serial_valid,
  output logic              serial_out,
  output logic              serial_start,
  output logic              serial_end,
  output logic              busy
);

  localparam int CNT_W = p2s_cnt_w(DATA_W);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

  if (!p2s_width_ok(DATA_W)) begin : g_bad_width
    $error("parallel2serial_stream: DATA_W=%0d outside legal range 2..64", DATA_W);
  end

  // The outgoing bit is registered separately, so sreg always holds the bits not yet sent,
  // already aligned so the next one sits at the transmit end.
  function automatic logic first_bit(input logic [DATA_W-1:0] w);
    return LSB_FIRST ? w[0] : w[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] drop_bit(input logic [DATA_W-1:0] w);
    return LSB_FIRST ? (w >> 1) : (w << 1);
  endfunction

  p2s_state_t        state, state_nxt;
  logic [DATA_W-1:0] sreg, sreg_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              valid_nxt, out_nxt, start_nxt, end_nxt;

  logic              hold_full;
  logic [DATA_W-1:0] hold_data;
  logic              xfer, last, load_hold, load_in, capture;
  logic [DATA_W-1:0] load_word;

  assign xfer      = in_valid && in_ready;
  assign last      = (state == SHIFT) && (cnt == LAST_CNT);
  // Frame end refills from the buffer first; with the buffer empty in_ready is high,
  // so a word offered on that same edge goes straight into sreg.
  assign load_hold = last && hold_full;
  assign load_in   = xfer && ((state == IDLE) || last);
  assign capture   = (state == SHIFT) && !last;
  assign load_word = load_hold ? hold_data : in_data;
  assign busy      = (state == SHIFT) || hold_full;

  p2s_hold_buf #(.DATA_W(DATA_W)) u_hold (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .capture   (capture),
    .pop       (load_hold),
    .in_ready  (in_ready),
    .hold_data (hold_data),
    .hold_full (hold_full)
  );

  always_comb begin
    state_nxt = state;
    sreg_nxt  = sreg;
    cnt_nxt   = cnt;
    valid_nxt = serial_valid;
    out_nxt   = serial_out;
    start_nxt = 1'b0;
    end_nxt   = 1'b0;
    if (load_hold || load_in) begin
      state_nxt = SHIFT;
      sreg_nxt  = drop_bit(load_word);
      cnt_nxt   = '0;
      valid_nxt = 1'b1;
      out_nxt   = first_bit(load_word);
      start_nxt = 1'b1;
    end else if (last) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      valid_nxt = 1'b0;
      out_nxt   = IDLE_LEVEL;
    end else if (state == SHIFT) begin
      sreg_nxt  = drop_bit(sreg);
      cnt_nxt   = cnt + CNT_W'(1);
      valid_nxt = 1'b1;
      out_nxt   = first_bit(sreg);
      end_nxt   = ((cnt + CNT_W'(1)) == LAST_CNT);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      sreg         <= '0;
      cnt          <= '0;
      serial_valid <= 1'b0;
      serial_out   <= IDLE_LEVEL;
      serial_start <= 1'b0;
      serial_end   <= 1'b0;
    end else begin
      state        <= state_nxt;
      sreg         <= sreg_nxt;
      cnt          <= cnt_nxt;
      serial_valid <= valid_nxt;
      serial_out   <= out_nxt;
      serial_start <= start_nxt;
      serial_end   <= end_nxt;
    end
  end

endmodule

// File: tb/tb_parallel2serial_stream.sv
// Self-checking bench: three configurations (8b MSB-first, 8b LSB-first idle-high,
// 16b MSB-first) driven word by word; expected bits queued at handshake, compared on output.
module tb_parallel2serial_stream;

  typedef struct packed {
    logic b;
    logic s;
    logic e;
    logic gapless;
  } exp_t;

  localparam int W_OF   [3] = '{8, 8, 16};
  localparam bit LSB_OF [3] = '{1'b0, 1'b1, 1'b0};
  localparam bit IDL_OF [3] = '{1'b0, 1'b1, 1'b0};

  logic        clk = 1'b0;
  logic        rst;
  logic        vld [3];
  logic [15:0] dat [3];
  logic        rdy [3];
  logic        sv  [3];
  logic        so  [3];
  logic        ss  [3];
  logic        se  [3];
  logic        bsy [3];

  exp_t q [3][$];
  logic prev_v [3];
  int   n_err = 0;
  int   n_chk = 0;

  always #5 clk = ~clk;

  parallel2serial_stream #(.DATA_W(8), .LSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u0 (
    .clk(clk), .rst(rst), .in_valid(vld[0]), .in_data(dat[0][7:0]), .in_ready(rdy[0]),
    .serial_valid(sv[0]), .serial_out(so[0]), .serial_start(ss[0]), .serial_end(se[0]),
    .busy(bsy[0]));

  parallel2serial_stream #(.DATA_W(8), .LSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) u1 (
    .clk(clk), .rst(rst), .in_valid(vld[1]), .in_data(dat[1][7:0]), .in_ready(rdy[1]),
    .serial_valid(sv[1]), .serial_out(so[1]), .serial_start(ss[1]), .serial_end(se[1]),
    .busy(bsy[1]));

  parallel2serial_stream #(.DATA_W(16), .LSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u2 (
    .clk(clk), .rst(rst), .in_valid(vld[2]), .in_data(dat[2]), .in_ready(rdy[2]),
    .serial_valid(sv[2]), .serial_out(so[2]), .serial_start(ss[2]), .serial_end(se[2]),
    .busy(bsy[2]));

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Offer one word to instance i; expected bits are queued just before the handshake edge.
  task automatic push_word(input int i, input logic [15:0] w, output int stall);
    int   w_bits;
    int   idx;
    exp_t e;
    logic gl;
    stall = 0;
    w_bits = W_OF[i];
    @(negedge clk);
    vld[i] = 1'b1;
    dat[i] = w;
    while (!rdy[i] && stall < 100) begin
      @(negedge clk);
      stall++;
    end
    chk($sformatf("u%0d ready_timeout", i), 32'(rdy[i]), 32'd1);
    gl = (q[i].size() > 0);
    for (int k = 0; k < w_bits; k++) begin
      idx = LSB_OF[i] ? k : (w_bits - 1 - k);
      e.b = w[idx];
      e.s = (k == 0);
      e.e = (k == w_bits - 1);
      e.gapless = (k > 0) || gl;
      q[i].push_back(e);
    end
    @(posedge clk);
    #1;
    vld[i] = 1'b0;
  endtask

  task automatic drain(input int i);
    int g = 0;
    do begin
      @(negedge clk);
      g++;
    end while ((q[i].size() != 0 || bsy[i]) && g < 300);
    chk($sformatf("u%0d drain_queue", i), 32'(q[i].size()), 32'd0);
    chk($sformatf("u%0d drain_busy", i), 32'(bsy[i]), 32'd0);
    chk($sformatf("u%0d drain_valid", i), 32'(sv[i]), 32'd0);
    chk($sformatf("u%0d drain_ready", i), 32'(rdy[i]), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  // Output monitor: every valid bit must match the queue head; idle cycles must sit at the
  // idle level with no strobes, and a queued gapless bit may not be preceded by a hole.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      for (int i = 0; i < 3; i++) prev_v[i] = 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (sv[i]) begin
          if (q[i].size() == 0) begin
            chk($sformatf("u%0d extra_bit", i), 32'(sv[i]), 32'd0);
          end else begin
            e = q[i].pop_front();
            chk($sformatf("u%0d bit", i), 32'(so[i]), 32'(e.b));
            chk($sformatf("u%0d start", i), 32'(ss[i]), 32'(e.s));
            chk($sformatf("u%0d end", i), 32'(se[i]), 32'(e.e));
          end
        end else begin
          chk($sformatf("u%0d idle_out", i), 32'(so[i]), 32'(IDL_OF[i]));
          chk($sformatf("u%0d idle_start", i), 32'(ss[i]), 32'd0);
          chk($sformatf("u%0d idle_end", i), 32'(se[i]), 32'd0);
          if (prev_v[i] && q[i].size() > 0 && q[i][0].gapless)
            chk($sformatf("u%0d gap", i), 32'(sv[i]), 32'd1);
        end
        prev_v[i] = sv[i];
      end
    end
  end

  task automatic chk_reset_outs(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("u%0d %s valid", i, tag), 32'(sv[i]), 32'd0);
      chk($sformatf("u%0d %s start", i, tag), 32'(ss[i]), 32'd0);
      chk($sformatf("u%0d %s end", i, tag), 32'(se[i]), 32'd0);
      chk($sformatf("u%0d %s out", i, tag), 32'(so[i]), 32'(IDL_OF[i]));
      chk($sformatf("u%0d %s busy", i, tag), 32'(bsy[i]), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    logic [15:0] w;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      vld[i] = 1'b0;
      dat[i] = '0;
      prev_v[i] = 1'b0;
    end
    #1;
    chk_reset_outs("reset");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++)
      chk($sformatf("u%0d post_reset_ready", i), 32'(rdy[i]), 32'd1);

    // Single words: MSB-first, LSB-first, 16-bit boundary pattern.
    push_word(0, 16'h00D3, st);
    drain(0);
    push_word(1, 16'h00D3, st);
    drain(1);
    push_word(2, 16'h8001, st);
    drain(2);

    // Back-to-back pair, then a third word that must stall until frame 1 ends.
    push_word(0, 16'h00D3, st);
    push_word(0, 16'h005A, st);
    chk("u0 second_word_stall", 32'(st), 32'd0);
    push_word(0, 16'h00C7, st);
    chk("u0 third_word_stall", 32'(st), 32'd7);
    drain(0);

    push_word(1, 16'h0081, st);
    push_word(1, 16'h003C, st);
    push_word(1, 16'h00E4, st);
    chk("u1 third_word_stall", 32'(st), 32'd7);
    drain(1);

    push_word(2, 16'hA55A, st);
    push_word(2, 16'h0FF0, st);
    push_word(2, 16'h1234, st);
    chk("u2 third_word_stall", 32'(st), 32'd15);
    drain(2);

    // Reset at bit 4 of a frame with a second word held.
    push_word(0, 16'h00D3, st);
    push_word(0, 16'h005A, st);
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("u0 pre_reset_valid", 32'(sv[0]), 32'd1);
    chk("u0 pre_reset_ready", 32'(rdy[0]), 32'd0);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) q[i].delete();
    #1;
    chk_reset_outs("async_reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("u0 ready_after_abort", 32'(rdy[0]), 32'd1);
    push_word(0, 16'h0096, st);
    drain(0);
    repeat (12) @(negedge clk);

    // Random streams on every instance.
    for (int i = 0; i < 3; i++) begin
      for (int n = 0; n < 5; n++) begin
        w = 16'($urandom);
        push_word(i, w, st);
      end
      drain(i);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
